raw_bayer_to_rgb: RTL and testbench
===================================

# raw_bayer_to_rgb

Demosaics the raw 12-bit Bayer stream from the CCD capture stage into one RGB pixel per 2x2 Bayer quad. It sits directly upstream of the processing chain that consumes `iCCD_R/G/B`, `iCCD_DVAL`, `iX_Cont`, `iY_Cont` and `iFval`. A raw 1600x960 frame becomes an 800x480 RGB frame. One raw line is buffered internally so each quad can be formed on its second row.

## Interface
- `DATA_W`, 12: raw and colour sample width.
- `RAW_WIDTH`, 1600: raw pixels per line; sets line-buffer depth (even, ≥4).
- `CCD_PIXCLK` in 1: pixel clock; all logic on rising edge.
- `iRst` in 1: reset. One clock; reset is synchronous and active-high.
- `iDATA` in DATA_W: raw Bayer sample.
- `iDVAL` in 1: iDATA valid this cycle.
- `iX_Cont` in 16: raw column of iDATA, 0..RAW_WIDTH-1.
- `iY_Cont` in 16: raw row of iDATA.
- `iFval` in 1: frame valid.
- `oRed`, `oGreen`, `oBlue` out DATA_W each: demosaiced colour.
- `oDVAL` out 1: RGB valid, single-cycle pulse per quad.
- `oX_Cont`, `oY_Cont` out 16: output coordinates (raw >> 1).
- `oFval` out 1: iFval delayed one cycle.

## Operation
- Bayer layout:
  - Even rows: G1 at even X, R at odd X.
  - Odd rows: B at even X, G2 at odd X.
- Line buffer behaviour:
  - Depth RAW_WIDTH, DATA_W wide.
  - Advances only on cycles with iDVAL=1. Gaps in iDVAL are legal and freeze all datapath state.
  - Its output tap is the sample at the same column one row earlier.
- Holding registers, updated on every accepted sample:
  - `cur_d`: previous current-row sample (column X-1).
  - `prv_d`: previous tap value (previous row, column X-1).
- Quad completes on an accepted sample with iX_Cont[0]=1 and iY_Cont[0]=1. Then:
  - R = tap (previous row, X).
  - G = (prv_d + iDATA) >> 1, with a DATA_W+1-bit sum and the LSB truncated.
  - B = cur_d (current row, X-1).
- `row_ok` flag:
  - Set when an accepted sample has iY_Cont[0]=0 and iX_Cont=RAW_WIDTH-1, i.e. a full even row is stored.
  - Cleared by reset and on the iFval rising edge.
  - oDVAL is asserted only when a quad completes and row_ok=1.
- On a qualifying quad: register the RGB values, oX_Cont=iX_Cont>>1, oY_Cont=iY_Cont>>1.
- Between pulses, oRed/oGreen/oBlue/oX_Cont/oY_Cont hold their last values.
- Samples with iFval=0 are ignored: no buffer advance, no output.

## Timing
- Latency: accepted G2 sample at cycle N → oDVAL=1 with RGB valid at cycle N+1.
- Output rate:
  - One oDVAL per 4 raw samples averaged over a row pair.
  - Maximum one pulse every 2 accepted samples within an odd row.
- Reset, asserted at any cycle including mid-frame:
  - Next edge: oRed/oGreen/oBlue=0, oX_Cont/oY_Cont=0, oDVAL=0, oFval=0, row_ok=0, cur_d/prv_d=0.
  - Line-buffer contents are don't-care because row_ok gates all output.
- After reset mid-frame: no oDVAL until a complete even row has been accepted after reset.
- iFval rising and a G2 sample in the same cycle: row_ok is cleared first, so no oDVAL.
- Wrap-around:
  - The column index is taken from iX_Cont, not from an internal counter.
  - A row ending early (X < RAW_WIDTH-1) leaves row_ok unchanged and does not corrupt later rows' alignment.
- Saturation is impossible: (2^DATA_W-1)*2 >> 1 = 2^DATA_W-1.

## Structure
- Shared package holds:
  - `BAYER_DATA_W`=12, `RAW_LINE_W`=1600, `RGB_LINE_W`=800, `FRAME_ROWS`=480.
  - The quad-position encoding (2-bit {Y[0],X[0]}: G1=00, R=01, B=10, G2=11).
- One sub-module, `bayer_line_buffer`:
  - Shift-register/RAM delay line of RAW_WIDTH x DATA_W with a clock-enable (iDVAL) and a single tap.
  - Reset-free: holds contents only, no output reset.

## Test plan
- Uniform raw frame, all samples 0x800 → every oDVAL has R=G=B=0x800; exactly 800x480 pulses per frame; oX_Cont spans 0..799, oY_Cont spans 0..479.
- Row 0 G1=100, R=200; row 1 B=300, G2=401 at X=0..1 → at cycle N+1: oRed=200, oGreen=250, oBlue=300, oX_Cont=0, oY_Cont=0.
- Max values G1=G2=0xFFF → oGreen=0xFFF with no overflow; G1=0xFFF, G2=0x000 → oGreen=0x7FF.
- iDVAL toggled 1,0,1,0 through a full row pair → identical RGB values to the gap-free run; oDVAL count unchanged.
- iRst pulsed during row 301 → outputs 0 the next cycle; no oDVAL for the rest of row 301; pulses resume on row 303 with correct values.
- iFval low between frames with iDVAL held at 1 and random data → no oDVAL; oFval follows iFval one cycle late.

Source files
------------

// File: rtl/raw_bayer_to_rgb_pkg.sv
// Shared constants and Bayer quad-position encoding for the raw-to-RGB demosaic.
package raw_bayer_to_rgb_pkg;

  localparam int BAYER_DATA_W = 12;
  localparam int RAW_LINE_W   = 1600;
  localparam int RGB_LINE_W   = 800;
  localparam int FRAME_ROWS   = 480;

  // Position of a raw sample inside its 2x2 quad, encoded as {Y[0], X[0]}.
  typedef enum logic [1:0] {
    QUAD_G1 = 2'b00,
    QUAD_R  = 2'b01,
    QUAD_B  = 2'b10,
    QUAD_G2 = 2'b11
  } quad_pos_e;

  function automatic quad_pos_e quad_pos(input logic y0, input logic x0);
    return quad_pos_e'({y0, x0});
  endfunction

endpackage

// File: rtl/raw_bayer_to_rgb_line_buffer.sv
// One-line delay for raw Bayer samples, addressed by the incoming column so that
// short rows cannot misalign later rows. The tap is the sample stored at the same
// column during the previous row. Holds data only; there is no reset.
module bayer_line_buffer #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 1600
) (
  input  logic              clk,
  input  logic              en,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tap
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic [AW-1:0]     idx;

  assign in_range = (addr < DEPTH16);
  assign idx      = addr[AW-1:0];

  // Read-before-write: the tap shows last row's sample at this column.
  always_comb begin
    tap = '0;
    if (in_range) tap = mem[idx];
  end

  // Store the accepted sample over the one just read out.
  always_ff @(posedge clk) begin
    if (en && in_range) mem[idx] <= din;
  end

endmodule

// File: rtl/raw_bayer_to_rgb.sv
// Demosaics a raw Bayer stream into one RGB pixel per 2x2 quad. The even row of
// each pair is held in a line buffer; the quad is formed when its G2 sample
// (odd row, odd column) arrives. Output is registered, one cycle after G2.
// Handshake: a sample is consumed only when iDVAL=1 and iFval=1; there is no
// back-pressure, and oDVAL is a single-cycle strobe qualifying oRed/oGreen/oBlue
// and oX_Cont/oY_Cont, which otherwise hold their last values.
module raw_bayer_to_rgb
  import raw_bayer_to_rgb_pkg::*;
#(
  parameter int DATA_W    = BAYER_DATA_W,
  parameter int RAW_WIDTH = RAW_LINE_W
) (
  input  logic              CCD_PIXCLK,
  input  logic              iRst,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [15:0]       iX_Cont,
  input  logic [15:0]       iY_Cont,
  input  logic              iFval,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic              oDVAL,
  output logic [15:0]       oX_Cont,
  output logic [15:0]       oY_Cont,
  output logic              oFval
);

  localparam logic [15:0] LAST_X = 16'(RAW_WIDTH - 1);

  logic              accept;
  logic              fval_d;
  logic              fval_rise;
  logic              row_ok;
  quad_pos_e         pos;
  logic [DATA_W-1:0] tap;
  logic [DATA_W-1:0] cur_d;
  logic [DATA_W-1:0] prv_d;
  logic [DATA_W:0]   g_sum;
  logic              even_row_done;
  logic              quad_done;
  logic              fire;

  assign accept    = iDVAL & iFval;
  assign fval_rise = iFval & ~fval_d;
  assign pos       = quad_pos(iY_Cont[0], iX_Cont[0]);

  bayer_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (RAW_WIDTH)
  ) u_line_buffer (
    .clk  (CCD_PIXCLK),
    .en   (accept & ~iRst),
    .addr (iX_Cont),
    .din  (iDATA),
    .tap  (tap)
  );

  // Green is the average of G1 (previous row, X-1) and G2 (this sample).
  assign g_sum = {1'b0, prv_d} + {1'b0, iDATA};

  assign even_row_done = accept && (pos == QUAD_G1 || pos == QUAD_R) && (iX_Cont == LAST_X);
  assign quad_done     = accept && (pos == QUAD_G2);
  // A frame start clears row_ok before this sample is considered.
  assign fire          = quad_done && row_ok && !fval_rise;

  // Frame-valid delay, used both as the output and for rising-edge detection.
  always_ff @(posedge CCD_PIXCLK) begin
    if (iRst) fval_d <= 1'b0;
    else      fval_d <= iFval;
  end

  assign oFval = fval_d;

  // row_ok: a complete even row has been stored since reset / frame start.
  always_ff @(posedge CCD_PIXCLK) begin
    if (iRst)               row_ok <= 1'b0;
    else if (fval_rise)     row_ok <= 1'b0;
    else if (even_row_done) row_ok <= 1'b1;
  end

  // Column X-1 history for the current row and for the line-buffer tap.
  always_ff @(posedge CCD_PIXCLK) begin
    if (iRst) begin
      cur_d <= '0;
      prv_d <= '0;
    end else if (accept) begin
      cur_d <= iDATA;
      prv_d <= tap;
    end
  end

  // Registered RGB result and coordinates; values hold between strobes.
  always_ff @(posedge CCD_PIXCLK) begin
    if (iRst) begin
      oDVAL   <= 1'b0;
      oRed    <= '0;
      oGreen  <= '0;
      oBlue   <= '0;
      oX_Cont <= '0;
      oY_Cont <= '0;
    end else begin
      oDVAL <= fire;
      if (fire) begin
        oRed    <= tap;
        oGreen  <= g_sum[DATA_W:1];
        oBlue   <= cur_d;
        oX_Cont <= {1'b0, iX_Cont[15:1]};
        oY_Cont <= {1'b0, iY_Cont[15:1]};
      end
    end
  end

endmodule

// File: tb/tb_raw_bayer_to_rgb.sv
// Bench for raw_bayer_to_rgb on a reduced 16x8 raw frame (8x4 RGB).
module tb_raw_bayer_to_rgb;

  localparam int DW   = 12;
  localparam int W    = 16;
  localparam int ROWS = 8;

  // clock / reset block
  logic          clk;
  logic          iRst;
  logic [DW-1:0] iDATA;
  logic          iDVAL;
  logic [15:0]   iX_Cont;
  logic [15:0]   iY_Cont;
  logic          iFval;
  logic [DW-1:0] oRed, oGreen, oBlue;
  logic          oDVAL;
  logic [15:0]   oX_Cont, oY_Cont;
  logic          oFval;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  raw_bayer_to_rgb #(.DATA_W(DW), .RAW_WIDTH(W)) dut (
    .CCD_PIXCLK (clk),
    .iRst       (iRst),
    .iDATA      (iDATA),
    .iDVAL      (iDVAL),
    .iX_Cont    (iX_Cont),
    .iY_Cont    (iY_Cont),
    .iFval      (iFval),
    .oRed       (oRed),
    .oGreen     (oGreen),
    .oBlue      (oBlue),
    .oDVAL      (oDVAL),
    .oX_Cont    (oX_Cont),
    .oY_Cont    (oY_Cont),
    .oFval      (oFval)
  );

  // scoreboard state
  logic [67:0] exp_q[$];
  logic [DW-1:0] raw [ROWS][W];
  int  total = 0;
  int  bad = 0;
  int  pulses = 0;
  bit  m_row_ok = 1'b0;
  bit  m_fval_prev = 1'b0;

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one cycle of input; expected pixels are derived from the raw frame
  task automatic drive(input logic rst, input logic fval, input logic dval,
                       input int x, input int y, input logic [DW-1:0] d);
    logic rise;
    logic [DW:0] gs;
    @(negedge clk);
    iRst = rst; iFval = fval; iDVAL = dval;
    iX_Cont = 16'(x); iY_Cont = 16'(y); iDATA = d;
    if (rst) begin
      m_row_ok = 1'b0;
      m_fval_prev = 1'b0;
    end else begin
      rise = fval && !m_fval_prev;
      if (fval && dval && (x % 2 == 1) && (y % 2 == 1) && m_row_ok && !rise
          && y < ROWS && x < W) begin
        gs = {1'b0, raw[y-1][x-1]} + {1'b0, raw[y][x]};
        exp_q.push_back({16'(x / 2), 16'(y / 2), raw[y-1][x], gs[DW:1], raw[y][x-1]});
      end
      if (rise) m_row_ok = 1'b0;
      else if (fval && dval && (y % 2 == 0) && x == W - 1) m_row_ok = 1'b1;
      m_fval_prev = fval;
    end
  endtask

  task automatic drive_px(input int x, input int y, input bit gap);
    drive(1'b0, 1'b1, 1'b1, x, y, raw[y][x]);
    if (gap) drive(1'b0, 1'b1, 1'b0, $urandom_range(0, W - 1), y, DW'($urandom));
  endtask

  task automatic drive_row(input int y, input bit gap);
    for (int x = 0; x < W; x++) drive_px(x, y, gap);
    drive(1'b0, 1'b1, 1'b0, 0, y, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0, '0);
  endtask

  task automatic drive_frame(input bit gap);
    idle(1);
    for (int y = 0; y < ROWS; y++) drive_row(y, gap);
    idle(3);
  endtask

  // mode 0 uniform 0x800, 1 directed quad, 2 all greens max, 3 G1 max/G2 zero, 4 random
  task automatic gen_frame(input int mode);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < W; x++) begin
        raw[y][x] = DW'($urandom);
        if (mode == 0) raw[y][x] = 12'h800;
        if (mode == 2 && (x % 2) == (y % 2)) raw[y][x] = 12'hFFF;
        if (mode == 3 && (x % 2) == 0 && (y % 2) == 0) raw[y][x] = 12'hFFF;
        if (mode == 3 && (x % 2) == 1 && (y % 2) == 1) raw[y][x] = 12'h000;
      end
    if (mode == 1) begin
      raw[0][0] = 12'd100; raw[0][1] = 12'd200;
      raw[1][0] = 12'd300; raw[1][1] = 12'd401;
    end
  endtask

  // frame with a direct look at the first quad one cycle after its G2 sample
  task automatic frame_with_probe(input string tag, input logic [DW-1:0] er,
                                  input logic [DW-1:0] eg, input logic [DW-1:0] eb);
    idle(1);
    drive_row(0, 1'b0);
    drive_px(0, 1, 1'b0);
    drive_px(1, 1, 1'b0);
    @(posedge clk); #1;
    check({tag, "_dval"}, 68'(oDVAL), 68'd1);
    check({tag, "_red"}, 68'(oRed), 68'(er));
    check({tag, "_green"}, 68'(oGreen), 68'(eg));
    check({tag, "_blue"}, 68'(oBlue), 68'(eb));
    check({tag, "_xy"}, 68'({oX_Cont, oY_Cont}), 68'd0);
    for (int x = 2; x < W; x++) drive_px(x, 1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 0, 1, '0);
    for (int y = 2; y < ROWS; y++) drive_row(y, 1'b0);
    idle(3);
  endtask

  // monitor: every strobe must match the oldest expected pixel
  always @(negedge clk) begin
    if (oDVAL === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_pulse observed x=%0d y=%0d expected none", oX_Cont, oY_Cont);
      end else begin
        check("pixel", {oX_Cont, oY_Cont, oRed, oGreen, oBlue}, exp_q.pop_front());
      end
    end
  end

  int cnt_plain;
  bit f;

  initial begin
    iRst = 1'b1; iFval = 1'b0; iDVAL = 1'b0;
    iX_Cont = '0; iY_Cont = '0; iDATA = '0;

    // reset state
    drive(1'b1, 1'b0, 1'b0, 0, 0, '0);
    drive(1'b1, 1'b0, 1'b0, 0, 0, '0);
    @(posedge clk); #1;
    check("rst_red", 68'(oRed), 68'd0);
    check("rst_green", 68'(oGreen), 68'd0);
    check("rst_blue", 68'(oBlue), 68'd0);
    check("rst_xy", 68'({oX_Cont, oY_Cont}), 68'd0);
    check("rst_dval", 68'(oDVAL), 68'd0);
    check("rst_fval", 68'(oFval), 68'd0);
    idle(2);

    // uniform frame: every pixel 0x800, 8x4 strobes, then outputs hold
    gen_frame(0);
    pulses = 0;
    drive_frame(1'b0);
    check("uniform_count", 68'(pulses), 68'(32));
    check("hold_xy", 68'({oX_Cont, oY_Cont}), 68'({16'd7, 16'd3}));
    check("hold_rgb", 68'({oRed, oGreen, oBlue}), 68'({12'h800, 12'h800, 12'h800}));
    check("hold_dval", 68'(oDVAL), 68'd0);

    // directed quad and green extremes
    gen_frame(1);
    frame_with_probe("quad", 12'd200, 12'd250, 12'd300);
    gen_frame(2);
    frame_with_probe("gmax", raw[0][1], 12'hFFF, raw[1][0]);
    gen_frame(3);
    frame_with_probe("ghalf", raw[0][1], 12'h7FF, raw[1][0]);

    // same random frame without and with iDVAL gaps
    gen_frame(4);
    pulses = 0;
    drive_frame(1'b0);
    cnt_plain = pulses;
    check("plain_count", 68'(cnt_plain), 68'(32));
    pulses = 0;
    drive_frame(1'b1);
    check("gap_count", 68'(pulses), 68'(cnt_plain));

    // reset in the middle of odd row 5; strobes resume only on row 7
    gen_frame(4);
    pulses = 0;
    idle(1);
    for (int y = 0; y < 5; y++) drive_row(y, 1'b0);
    for (int x = 0; x < 6; x++) drive_px(x, 5, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 6, 5, raw[5][6]);
    @(posedge clk); #1;
    check("midrst_rgb", 68'({oRed, oGreen, oBlue}), 68'd0);
    check("midrst_xy", 68'({oX_Cont, oY_Cont}), 68'd0);
    check("midrst_dval", 68'(oDVAL), 68'd0);
    for (int x = 7; x < W; x++) drive_px(x, 5, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 0, 5, '0);
    drive_row(6, 1'b0);
    drive_row(7, 1'b0);
    idle(3);
    check("midrst_count", 68'(pulses), 68'(27));

    // frame invalid with data valid: nothing must come out
    pulses = 0;
    for (int i = 0; i < 20; i++)
      drive(1'b0, 1'b0, 1'b1, $urandom_range(0, W - 1), $urandom_range(0, ROWS - 1), DW'($urandom));
    idle(2);
    check("fval_low_count", 68'(pulses), 68'd0);

    // oFval is iFval one cycle late
    for (int i = 0; i < 10; i++) begin
      f = (i % 3 != 0);
      drive(1'b0, f, 1'b0, 0, 0, '0);
      @(posedge clk); #1;
      check("fval_delay", 68'(oFval), 68'(f));
    end
    idle(3);

    check("queue_empty", 68'(exp_q.size()), 68'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
